// File: rtl/fifo_selftest_gen.sv
// fifo_selftest_gen
// FIFO loop-back self-test engine. A pattern generator fills an internal
// synchronous FIFO, a checker drains it and compares each word against an
// identical local generator. The write and read gaps throttle each side
// independently, so a run can push the FIFO to full or keep it near empty.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   start, pattern_sel  launch a run (IDLE/DONE only); pattern choice
//   wr_gap, rd_gap      idle cycles inserted after each write / read
//   inject_err          pulse: flip bit 0 of the next written word
//   busy, done, pass    run status
//   error_flag, err_count, first_err_*  mismatch reporting
//   fifo_full, fifo_empty, fifo_level, debug_data_out  FIFO observation
//
// Build option: FIFO_SELFTEST_PRBS_EN compiles in the PRBS31 (x^31+x^28+1)
// generator/checker. Without it the counter pattern is always used.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// RUN    | generator writing, checker reading
// DRAIN  | all words written, checker emptying the FIFO
// DONE   | results held until next start
module fifo_selftest_gen #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int TEST_LEN   = 256,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pattern_sel,
    input  logic [3:0]            wr_gap,
    input  logic [3:0]            rd_gap,
    input  logic                  inject_err,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  error_flag,
    output logic [CNT_W-1:0]      err_count,
    output logic [CNT_W-1:0]      first_err_idx,
    output logic [DATA_W-1:0]     first_err_data,
    output logic [DATA_W-1:0]     first_err_expect,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic [DATA_W-1:0]     debug_data_out
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [CNT_W-1:0] LEN = CNT_W'(TEST_LEN);

    logic [1:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d, chk_cnt_q, chk_cnt_d;
    logic [3:0]            wr_gap_cnt_q, wr_gap_cnt_d, rd_gap_cnt_q, rd_gap_cnt_d;
    logic [CNT_W-1:0]      err_cnt_q, err_cnt_d, first_idx_q, first_idx_d;
    logic                  err_flag_q, err_flag_d;
    logic [DATA_W-1:0]     first_data_q, first_data_d, first_exp_q, first_exp_d;
    logic                  inj_pend_q, inj_pend_d, chk_pend_q, chk_pend_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic [DATA_W-1:0]     wr_pat_q, wr_pat_d, chk_pat_q, chk_pat_d;
    logic [DATA_W-1:0]     mem_q [DEPTH];

    logic run_start, is_busy, full, empty, wr_en, rd_en, inj_now;
    logic [DATA_W-1:0] wr_word, chk_word, wr_data;

`ifdef FIFO_SELFTEST_PRBS_EN
    logic [30:0] wr_lfsr_q, wr_lfsr_d, chk_lfsr_q, chk_lfsr_d;
    logic        pat_sel_q, pat_sel_d;

    function automatic logic [30:0] lfsr_step(input logic [30:0] s);
        return {s[29:0], s[30] ^ s[27]};
    endfunction
`else
    logic unused_pattern_sel;
    assign unused_pattern_sel = pattern_sel;
`endif

    assign run_start = start && (state_q == S_IDLE || state_q == S_DONE);
    assign is_busy   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign full      = (level_q == (DEPTH_LOG2+1)'(DEPTH));
    assign empty     = (level_q == '0);
    assign wr_en     = (state_q == S_RUN) && !full && (wr_cnt_q < LEN) && (wr_gap_cnt_q == 4'd0);
    assign rd_en     = is_busy && !empty && (rd_gap_cnt_q == 4'd0);
    // A pulse coinciding with a write corrupts that same write.
    assign inj_now   = inj_pend_q || (inject_err && is_busy);

`ifdef FIFO_SELFTEST_PRBS_EN
    assign wr_word  = pat_sel_q ? wr_lfsr_q[DATA_W-1:0]  : wr_pat_q;
    assign chk_word = pat_sel_q ? chk_lfsr_q[DATA_W-1:0] : chk_pat_q;
`else
    assign wr_word  = wr_pat_q;
    assign chk_word = chk_pat_q;
`endif
    assign wr_data = wr_word ^ DATA_W'(inj_now);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        wr_cnt_d     = wr_cnt_q;
        chk_cnt_d    = chk_cnt_q;
        wr_gap_cnt_d = wr_gap_cnt_q;
        rd_gap_cnt_d = rd_gap_cnt_q;
        err_cnt_d    = err_cnt_q;
        err_flag_d   = err_flag_q;
        first_idx_d  = first_idx_q;
        first_data_d = first_data_q;
        first_exp_d  = first_exp_q;
        inj_pend_d   = inj_pend_q;
        chk_pend_d   = 1'b0;
        rd_data_d    = rd_data_q;
        wr_pat_d     = wr_pat_q;
        chk_pat_d    = chk_pat_q;
`ifdef FIFO_SELFTEST_PRBS_EN
        wr_lfsr_d    = wr_lfsr_q;
        chk_lfsr_d   = chk_lfsr_q;
        pat_sel_d    = pat_sel_q;
`endif
        if (run_start) begin
            state_d      = S_RUN;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            wr_cnt_d     = '0;
            chk_cnt_d    = '0;
            wr_gap_cnt_d = '0;
            rd_gap_cnt_d = '0;
            err_cnt_d    = '0;
            err_flag_d   = 1'b0;
            first_idx_d  = '0;
            first_data_d = '0;
            first_exp_d  = '0;
            inj_pend_d   = 1'b0;
            wr_pat_d     = '0;
            chk_pat_d    = '0;
`ifdef FIFO_SELFTEST_PRBS_EN
            wr_lfsr_d    = '1;
            chk_lfsr_d   = '1;
            pat_sel_d    = pattern_sel;
`endif
        end else begin
            case (state_q)
                S_RUN:   if (wr_cnt_q == LEN) state_d = S_DRAIN;
                S_DRAIN: if (chk_cnt_q == LEN) state_d = S_DONE;
                default: state_d = state_q;
            endcase

            if (wr_en) begin
                wr_ptr_d     = wr_ptr_q + 1'b1;
                wr_cnt_d     = wr_cnt_q + 1'b1;
                wr_gap_cnt_d = wr_gap;
                wr_pat_d     = wr_pat_q + 1'b1;
                inj_pend_d   = 1'b0;
`ifdef FIFO_SELFTEST_PRBS_EN
                wr_lfsr_d    = lfsr_step(wr_lfsr_q);
`endif
            end else begin
                inj_pend_d = inj_now;
                if (wr_gap_cnt_q != 4'd0) wr_gap_cnt_d = wr_gap_cnt_q - 4'd1;
            end

            if (rd_en) begin
                rd_ptr_d     = rd_ptr_q + 1'b1;
                rd_gap_cnt_d = rd_gap;
                rd_data_d    = mem_q[rd_ptr_q];
                chk_pend_d   = 1'b1;
            end else if (rd_gap_cnt_q != 4'd0) begin
                rd_gap_cnt_d = rd_gap_cnt_q - 4'd1;
            end

            case ({wr_en, rd_en})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase

            // Word read on the previous edge is compared now.
            if (chk_pend_q) begin
                chk_cnt_d = chk_cnt_q + 1'b1;
                chk_pat_d = chk_pat_q + 1'b1;
`ifdef FIFO_SELFTEST_PRBS_EN
                chk_lfsr_d = lfsr_step(chk_lfsr_q);
`endif
                if (rd_data_q != chk_word) begin
                    err_flag_d = 1'b1;
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                    if (!err_flag_q) begin
                        first_idx_d  = chk_cnt_q;
                        first_data_d = rd_data_q;
                        first_exp_d  = chk_word;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            wr_cnt_q     <= '0;
            chk_cnt_q    <= '0;
            wr_gap_cnt_q <= '0;
            rd_gap_cnt_q <= '0;
            err_cnt_q    <= '0;
            err_flag_q   <= 1'b0;
            first_idx_q  <= '0;
            first_data_q <= '0;
            first_exp_q  <= '0;
            inj_pend_q   <= 1'b0;
            chk_pend_q   <= 1'b0;
            rd_data_q    <= '0;
            wr_pat_q     <= '0;
            chk_pat_q    <= '0;
`ifdef FIFO_SELFTEST_PRBS_EN
            wr_lfsr_q    <= '1;
            chk_lfsr_q   <= '1;
            pat_sel_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            wr_cnt_q     <= wr_cnt_d;
            chk_cnt_q    <= chk_cnt_d;
            wr_gap_cnt_q <= wr_gap_cnt_d;
            rd_gap_cnt_q <= rd_gap_cnt_d;
            err_cnt_q    <= err_cnt_d;
            err_flag_q   <= err_flag_d;
            first_idx_q  <= first_idx_d;
            first_data_q <= first_data_d;
            first_exp_q  <= first_exp_d;
            inj_pend_q   <= inj_pend_d;
            chk_pend_q   <= chk_pend_d;
            rd_data_q    <= rd_data_d;
            wr_pat_q     <= wr_pat_d;
            chk_pat_q    <= chk_pat_d;
`ifdef FIFO_SELFTEST_PRBS_EN
            wr_lfsr_q    <= wr_lfsr_d;
            chk_lfsr_q   <= chk_lfsr_d;
            pat_sel_q    <= pat_sel_d;
`endif
        end
    end

    // Storage is not reset; pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign busy             = is_busy;
    assign done             = (state_q == S_DONE);
    assign pass             = (state_q == S_DONE) && (err_cnt_q == '0);
    assign error_flag       = err_flag_q;
    assign err_count        = err_cnt_q;
    assign first_err_idx    = first_idx_q;
    assign first_err_data   = first_data_q;
    assign first_err_expect = first_exp_q;
    assign fifo_full        = full;
    assign fifo_empty       = empty;
    assign fifo_level       = level_q;
    assign debug_data_out   = rd_data_q;
endmodule

// File: tb/tb_fifo_selftest_gen.sv
module tb_fifo_selftest_gen;
    localparam int DATA_W     = 8;
    localparam int DEPTH_LOG2 = 4;
    localparam int TEST_LEN   = 256;
    localparam int CNT_W      = 16;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int BUDGET     = 20000;

    logic clk = 1'b0;
    logic reset, start, pattern_sel, inject_err;
    logic [3:0] wr_gap, rd_gap;
    logic busy, done, pass, error_flag, fifo_full, fifo_empty;
    logic [CNT_W-1:0] err_count, first_err_idx;
    logic [DATA_W-1:0] first_err_data, first_err_expect, debug_data_out;
    logic [DEPTH_LOG2:0] fifo_level;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_selftest_gen #(
        .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .TEST_LEN(TEST_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pattern_sel(pattern_sel),
        .wr_gap(wr_gap), .rd_gap(rd_gap), .inject_err(inject_err),
        .busy(busy), .done(done), .pass(pass), .error_flag(error_flag),
        .err_count(err_count), .first_err_idx(first_err_idx),
        .first_err_data(first_err_data), .first_err_expect(first_err_expect),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
        .debug_data_out(debug_data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference pattern: word k of a run, straight from the pattern definition.
    function automatic logic [DATA_W-1:0] exp_word(input int k, input logic psel);
        logic [30:0] s;
        s = '1;
        if (!psel) return DATA_W'(k);
        for (int i = 0; i < k; i++) s = {s[29:0], s[30] ^ s[27]};
        return s[DATA_W-1:0];
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_flags"}, 64'({busy, done, pass, error_flag, fifo_full, fifo_empty, fifo_level}),
              64'({6'b000001, 5'd0}));
        check({tag, "_cnts"}, 64'({err_count, first_err_idx}), 64'd0);
        check({tag, "_data"}, 64'({first_err_data, first_err_expect, debug_data_out}), 64'd0);
    endtask

    // One run. inj_at / rst_at: cycle after the start edge at which to pulse
    // inject_err / assert reset (-1 = never).
    task automatic do_run(input logic [3:0] wg, input logic [3:0] rg, input logic psel,
                          input int inj_at, input int rst_at, input string tag);
        int n, max_lvl, empty_rises, incons, done_n;
        logic full_seen, prev_empty, got_done, eff_psel;
        logic [DATA_W-1:0] first_dbg, last_exp;
        n = 0; max_lvl = 0; empty_rises = 0; incons = 0; done_n = -1;
        full_seen = 1'b0; got_done = 1'b0; first_dbg = '0;
`ifdef FIFO_SELFTEST_PRBS_EN
        eff_psel = psel;
`else
        eff_psel = 1'b0;
`endif
        @(negedge clk);
        wr_gap = wg; rd_gap = rg; pattern_sel = psel; start = 1'b1;
        prev_empty = fifo_empty;
        @(posedge clk);
        while (n < BUDGET) begin
            @(negedge clk);
            start = 1'b0;
            if (rst_at >= 0 && n == rst_at + 1) begin
                reset = 1'b0;
                check_reset_state({tag, "_midrst"});
                return;
            end
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            if (fifo_full) full_seen = 1'b1;
            if (fifo_empty && !prev_empty) empty_rises++;
            prev_empty = fifo_empty;
            if (fifo_full != (int'(fifo_level) == DEPTH) || fifo_empty != (fifo_level == 0)) incons++;
            if (n == 2) first_dbg = debug_data_out;
            if (done) begin
                got_done = 1'b1;
                done_n = n;
                break;
            end
            inject_err = (n == inj_at);
            reset = (n == rst_at);
            @(posedge clk);
            n++;
        end
        inject_err = 1'b0;
        check({tag, "_done_seen"}, 64'(got_done), 64'd1);
        check({tag, "_flag_consistency"}, 64'(incons), 64'd0);
        check({tag, "_max_level_le_depth"}, 64'(max_lvl <= DEPTH), 64'd1);
        last_exp = exp_word(TEST_LEN - 1, eff_psel);
        check({tag, "_last_read"}, 64'(debug_data_out), 64'(last_exp));
        if (wg == 0 && rg == 0) begin
            check({tag, "_done_cycle"}, 64'(done_n), 64'(TEST_LEN + 3));
            check({tag, "_max_level"}, 64'(max_lvl), 64'd1);
            check({tag, "_first_word"}, 64'(first_dbg), 64'(exp_word(0, eff_psel)));
        end
        if (rg > wg) begin
            check({tag, "_full_seen"}, 64'(full_seen), 64'd1);
            check({tag, "_full_level"}, 64'(max_lvl), 64'(DEPTH));
        end
        if (wg > 0 && rg == 0)
            check({tag, "_empty_toggles"}, 64'(empty_rises >= TEST_LEN - 1), 64'd1);
        if (inj_at >= 0) begin
            check({tag, "_err_count"}, 64'(err_count), 64'd1);
            check({tag, "_first_idx"}, 64'(first_err_idx), 64'(inj_at));
            check({tag, "_first_data"}, 64'(first_err_data), 64'(exp_word(inj_at, eff_psel) ^ 8'h01));
            check({tag, "_first_expect"}, 64'(first_err_expect), 64'(exp_word(inj_at, eff_psel)));
            check({tag, "_pass_flag"}, 64'({pass, error_flag}), 64'b01);
        end else begin
            check({tag, "_err_count"}, 64'(err_count), 64'd0);
            check({tag, "_pass_flag"}, 64'({pass, error_flag}), 64'b10);
        end
        check({tag, "_idle_outputs"}, 64'({busy, done, fifo_empty}), 64'b011);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pattern_sel = 1'b0; inject_err = 1'b0;
        wr_gap = 4'd0; rd_gap = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;

        do_run(4'd0, 4'd0, 1'b0, -1, -1, "base");
        do_run(4'd0, 4'd3, 1'b0, -1, -1, "rdgap3");
        do_run(4'd5, 4'd0, 1'b0, -1, -1, "wrgap5");
        do_run(4'd0, 4'd0, 1'b0, 10, -1, "inject");
        do_run(4'd0, 4'd0, 1'b1, -1, -1, "prbs");
        do_run(4'd0, 4'd0, 1'b1, -1, -1, "prbs_again");
        do_run(4'd0, 4'd0, 1'b0, -1, 100, "midrst");
        do_run(4'd0, 4'd0, 1'b0, -1, -1, "after_rst");
        for (int r = 0; r < 4; r++) begin
            logic [3:0] wg, rg;
            logic ps;
            wg = 4'($urandom_range(0, 15));
            rg = 4'($urandom_range(0, 15));
            ps = 1'($urandom % 2);
            do_run(wg, rg, ps, -1, -1, $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_selftest_gen.md
# fifo_selftest_gen

Parametrised FIFO loop-back self-test engine. It contains its own synchronous FIFO of configurable width and depth, a pattern generator on the write side and a pattern checker on the read side. Independent write and read throttling lets the bench drive the FIFO to full and to empty. It reports pass/fail, an error count and first-mismatch capture, and is used as a board-level health check alongside the status LEDs.

## Interface
- DATA_W, 8: FIFO word width; legal range 1..31.
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 words.
- TEST_LEN, 256: words written and checked per run; must be at least 1.
- CNT_W, 16: width of the word index and error counters.

- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launches a run; accepted only in IDLE or DONE.
- pattern_sel  in  1  0 = counter pattern, 1 = PRBS; sampled when start is accepted.
- wr_gap  in  4  idle cycles inserted after each write.
- rd_gap  in  4  idle cycles inserted after each read.
- inject_err  in  1  1-cycle pulse; inverts bit 0 of the next written word.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- pass  out  1  high when done is high and err_count == 0.
- error_flag  out  1  sticky; set on the first mismatch.
- err_count  out  CNT_W  number of mismatches; saturates at all-ones.
- first_err_idx  out  CNT_W  read index (0-based) of the first mismatch.
- first_err_data  out  DATA_W  word read at the first mismatch.
- first_err_expect  out  DATA_W  expected word at the first mismatch.
- fifo_full  out  1  FIFO level equals 2^DEPTH_LOG2.
- fifo_empty  out  1  FIFO level equals 0.
- fifo_level  out  DEPTH_LOG2+1  current FIFO occupancy.
- debug_data_out  out  DATA_W  FIFO read-data register.

## Operation
- State machine: IDLE -> RUN on start. RUN -> DRAIN when wr_cnt == TEST_LEN. DRAIN -> DONE when chk_cnt == TEST_LEN. DONE -> RUN on start.
- start received in RUN or DRAIN is ignored.
- Entering RUN clears, in the same edge: FIFO pointers and level, wr_cnt, rd_cnt, chk_cnt, gap counters, err_count, error_flag, all first_err_* outputs and any pending inject.
- Write enable is combinational: state RUN, !fifo_full, wr_cnt < TEST_LEN, and write-gap counter == 0.
  - Each write loads the gap counter with wr_gap.
  - The gap counter decrements to 0 on the following cycles.
- Read enable is combinational: state RUN or DRAIN, !fifo_empty, and read-gap counter == 0. It uses rd_gap the same way.
- FIFO rules:
  - Writes are never presented while full; reads are never presented while empty.
  - A simultaneous read and write leaves the level unchanged.
  - Pointers wrap modulo 2^DEPTH_LOG2.
- Counter pattern: word k = k mod 2^DATA_W, starting at 0 and wrapping.
- PRBS pattern:
  - 31-bit LFSR x^31+x^28+1, seeded to all ones at run start and stepped once per word.
  - Word = low DATA_W bits of the LFSR state before the step.
  - The checker runs an identical copy.
- Checker: compares the read-data register against the expected word in the cycle after each read, then increments chk_cnt.
- On mismatch:
  - error_flag is set.
  - err_count increments, saturating at all-ones.
  - If error_flag was previously clear, first_err_idx, first_err_data and first_err_expect are captured.
- inject_err pulses while busy set a single pending flag. The next write inverts bit 0 and clears the flag. Further pulses while the flag is pending are absorbed.
- Results hold in DONE until the next accepted start, or until reset.
- Reset, including mid-run:
  - Returns to IDLE.
  - fifo_empty resets to 1.
  - Every other output resets to 0.
  - FIFO contents need not be cleared.

## Timing
- start sampled high at edge 0 → busy high after edge 0. The first write is presented in the cycle following edge 0.
- With wr_gap = rd_gap = 0 and no stalls:
  - One write and one read per cycle.
  - Read data is compared one cycle after its read.
  - done rises exactly TEST_LEN+3 cycles after the start edge (259 for TEST_LEN = 256).
- Level peaks at 1 when both gaps are 0. With rd_gap > wr_gap the FIFO fills and writes stall on fifo_full until a read frees a slot.
- debug_data_out updates one cycle after each accepted read.

## Configuration
- FIFO_SELFTEST_PRBS_EN defined: the LFSR generator and checker are compiled in, and pattern_sel selects the pattern.
- FIFO_SELFTEST_PRBS_EN undefined: no LFSR logic is built, pattern_sel is ignored, and the counter pattern is always used.

## Test plan
- Defaults, counter, gaps 0, pulse start → done at cycle 259, pass = 1, err_count = 0, fifo_level never exceeds 1.
- wr_gap = 0, rd_gap = 3 → fifo_full reaches 1 with fifo_level = 16; writes stall while full; pass = 1 after all 256 words are checked.
- wr_gap = 5, rd_gap = 0 → fifo_empty toggles between words; pass = 1; debug_data_out of the last read = 255.
- Pulse inject_err after the 10th write → err_count = 1, first_err_idx = 10, first_err_data = 0x0B, first_err_expect = 0x0A, pass = 0, error_flag = 1.
- PRBS (macro defined), pattern_sel = 1 → first checked word = 0xFF, pass = 1. A second start in DONE re-clears all counters and gives pass = 1 again.
- reset asserted at cycle 100 of a run → next cycle: state IDLE, fifo_empty = 1, all other outputs 0; a fresh start then gives pass = 1.
